mix_columns_iter: RTL

- Iterative AES MixColumns stage. Sits directly downstream of the ShiftRows stage in the round datapath and consumes its four 32-bit row outputs.
- Latches one 128-bit state, then transforms COLS_PER_CYCLE columns per clock. Returns the result in the same row format under a valid/ready handshake.
- A per-block bypass serves the final round, which has no MixColumns.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/mix_column.sv | 26 ++
 rtl/mix_columns_iter.sv | 113 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, column types, FSM encoding and MixColumns coefficients.
// Latency: n/a (functions and types only).
// Backpressure: n/a.
package aes_pkg;

  // Low byte of the reduction polynomial x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] AES_POLY = 8'h1B;

  // One state column; element 0 is row 0 and sits in the most significant byte
  typedef logic [0:3][7:0] col_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // First row of each circulant matrix; row i is this row rotated right by i
  localparam col_t FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam col_t INV_COEF = {8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant coefficient this folds to a few XORs
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Circulant matrix-vector product: out[i] = XOR_j coef[(j-i) mod 4] * a[j]
  function automatic col_t mix_col(input col_t a, input col_t coef);
    col_t r;
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) begin
        r[i] = r[i] ^ gmul(a[j], coef[(j - i + 4) % 4]);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mix_column.sv
// Single-column MixColumns transform (inverse selectable when MIXCOL_INV_EN is defined).
// Latency: purely combinational.
// Backpressure: none; the caller owns all handshaking.
module mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
`ifdef MIXCOL_INV_EN
  input  logic        inv,
`endif
  output logic [31:0] col_out
);

  col_t fwd;

  assign fwd = mix_col(col_t'(col_in), FWD_COEF);

`ifdef MIXCOL_INV_EN
  col_t bwd;
  assign bwd     = mix_col(col_t'(col_in), INV_COEF);
  assign col_out = inv ? bwd : fwd;
`else
  assign col_out = fwd;
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns over a 128-bit row-format state, COLS_PER_CYCLE columns per clock; MIXCOL_INV_EN adds in_inv.
// Latency: 1 + 4/COLS_PER_CYCLE cycles accept-to-out_valid, 1 cycle with in_bypass.
// Backpressure: result held in DONE until out_ready; in_ready is low from accept until the result is taken.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_bypass,
`ifdef MIXCOL_INV_EN
  input  logic        in_inv,
`endif
  input  logic [31:0] rowin1,
  input  logic [31:0] rowin2,
  input  logic [31:0] rowin3,
  input  logic [31:0] rowin4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rowout1,
  output logic [31:0] rowout2,
  output logic [31:0] rowout3,
  output logic [31:0] rowout4
);

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] COL_LAST = 2'(4 - COLS_PER_CYCLE);

  state_t state;
  state_t state_nxt;
  logic [1:0] col;
  // st_q[row][column]; column 0 is the most significant byte of a row
  logic [0:3][0:3][7:0] st_q;
  logic accept;

  logic [1:0]  grp_idx [COLS_PER_CYCLE];
  logic [31:0] mc_out  [COLS_PER_CYCLE];

`ifdef MIXCOL_INV_EN
  logic inv_q;
`endif

  assign accept = in_valid && (state == ST_IDLE);

  // One transform per column in the current group
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign grp_idx[g] = col + 2'(g);
    mix_column u_mix_column (
      .col_in  ({st_q[0][grp_idx[g]], st_q[1][grp_idx[g]],
                 st_q[2][grp_idx[g]], st_q[3][grp_idx[g]]}),
`ifdef MIXCOL_INV_EN
      .inv     (inv_q),
`endif
      .col_out (mc_out[g])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: bypass skips CALC, last column group ends CALC, handshake ends DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = in_bypass ? ST_DONE : ST_CALC;
      ST_CALC: if (col == COL_LAST) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state so reset clears them at once
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Working registers: load on accept, overwrite one column group per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
      col  <= 2'd0;
`ifdef MIXCOL_INV_EN
      inv_q <= 1'b0;
`endif
    end else if (accept) begin
      st_q <= {rowin1, rowin2, rowin3, rowin4};
      col  <= 2'd0;
`ifdef MIXCOL_INV_EN
      inv_q <= in_inv;
`endif
    end else if (state == ST_CALC) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
        for (int r = 0; r < 4; r++) begin
          st_q[r][grp_idx[g]] <= mc_out[g][31 - 8*r -: 8];
        end
      end
      col <= col + COL_STEP;
    end
  end

  assign rowout1 = st_q[0];
  assign rowout2 = st_q[1];
  assign rowout3 = st_q[2];
  assign rowout4 = st_q[3];

endmodule
